// File: rtl/y86_pkg.sv
// Shared Y86 register-writeback types: register IDs, data width, pending-write entry
// and the scheduler occupancy states.
package y86_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 64;

  localparam logic [REG_W-1:0] RNONE = 4'hF;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    ACTIVE,
    NEAR_FULL
  } sched_state_e;

  // NEAR_FULL starts one entry short of full: a request may carry two results.
  function automatic sched_state_e state_of(input int cnt, input int depth);
    if (cnt == 0)              return EMPTY;
    else if (cnt >= depth - 1) return NEAR_FULL;
    return ACTIVE;
  endfunction

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Writeback-request / register-file-write / hazard bus of regfile_wr_sched.
// Forwarding signals exist only when WR_BYPASS_EN is defined.
interface regfile_wr_sched_if
  import y86_pkg::*;
#(
  parameter int DEPTH = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              req_valid;
  logic              req_ready;
  logic [REG_W-1:0]  dstE;
  logic [DATA_W-1:0] valE;
  logic [REG_W-1:0]  dstM;
  logic [DATA_W-1:0] valM;

  logic              wr_en;
  logic [REG_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [REG_W-1:0]  srcA;
  logic [REG_W-1:0]  srcB;
  logic              hazA;
  logic              hazB;
  logic [CNT_W-1:0]  pend_cnt;

`ifdef WR_BYPASS_EN
  logic              fwdA_valid;
  logic [DATA_W-1:0] fwdA_data;
  logic              fwdB_valid;
  logic [DATA_W-1:0] fwdB_data;
`endif

  modport master (
    output req_valid, dstE, valE, dstM, valM, srcA, srcB,
`ifdef WR_BYPASS_EN
    input  fwdA_valid, fwdA_data, fwdB_valid, fwdB_data,
`endif
    input  req_ready, wr_en, wr_addr, wr_data, hazA, hazB, pend_cnt
  );

  modport slave (
    input  req_valid, dstE, valE, dstM, valM, srcA, srcB,
`ifdef WR_BYPASS_EN
    output fwdA_valid, fwdA_data, fwdB_valid, fwdB_data,
`endif
    output req_ready, wr_en, wr_addr, wr_data, hazA, hazB, pend_cnt
  );

endinterface

// File: rtl/wr_fifo.sv
// Pending-write circular buffer: accepts zero, one or two entries per cycle and
// retires at most one from the head; all storage is visible for hazard matching.
module wr_fifo
  import y86_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               i_push_n,
  input  entry_t                   i_push0,
  input  entry_t                   i_push1,
  input  logic                     i_pop,
  output entry_t                   o_mem [DEPTH],
  output logic [$clog2(DEPTH)-1:0] o_head,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic [$clog2(DEPTH):0]   o_cnt_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_cnt;

  logic             w_pop;
  logic [PTR_W-1:0] w_tail1;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_pop      = i_pop && (r_cnt != '0);
  assign w_tail1    = r_tail + PTR_W'(1);
  assign w_cnt_next = r_cnt + CNT_W'(i_push_n) - CNT_W'(w_pop);

  // NOTE: the entry array is reset along with the pointers so that no stale
  // address survives a reset; storage without that need would skip the reset.
  // NOTE: all state here uses non-blocking assignment so every read in this
  // block sees the pre-edge value, matching the hardware registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push_n != 2'd0) r_mem[r_tail]  <= i_push0;
      if (i_push_n == 2'd2) r_mem[w_tail1] <= i_push1;
      r_tail <= r_tail + PTR_W'(i_push_n);
      if (w_pop) r_head <= r_head + PTR_W'(1);
      r_cnt <= w_cnt_next;
    end
  end

  assign o_mem      = r_mem;
  assign o_head     = r_head;
  assign o_cnt      = r_cnt;
  assign o_cnt_next = w_cnt_next;

endmodule

// File: rtl/regfile_wr_sched.sv
// Serialises the two writeback results of each instruction onto one register-file
// write port and flags decode reads that hit a pending write. Option: WR_BYPASS_EN.
module regfile_wr_sched
  import y86_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  regfile_wr_sched_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sched_state_e     r_state;

  logic             w_ready;
  logic             w_e_ok;
  logic             w_m_ok;
  logic             w_accept;
  logic [1:0]       w_push_n;
  entry_t           w_push0;
  entry_t           w_push1;
  entry_t           w_mem [DEPTH];
  logic [PTR_W-1:0] w_head;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_wr_en;
  entry_t           w_head_ent;
  logic             w_haz_a;
  logic             w_haz_b;
`ifdef WR_BYPASS_EN
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;
`endif

  assign w_ready  = (r_state != NEAR_FULL);
  assign w_e_ok   = (bus.dstE != RNONE);
  assign w_m_ok   = (bus.dstM != RNONE);
  assign w_accept = bus.req_valid && w_ready;
  assign w_push_n = w_accept ? (2'(w_e_ok) + 2'(w_m_ok)) : 2'd0;

  // E always precedes M, so with dstE == dstM the M value is written last.
  assign w_push0 = w_e_ok ? entry_t'{addr: bus.dstE, data: bus.valE}
                          : entry_t'{addr: bus.dstM, data: bus.valM};
  assign w_push1 = entry_t'{addr: bus.dstM, data: bus.valM};

  wr_fifo #(.DEPTH(DEPTH)) u_wr_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_n   (w_push_n),
    .i_push0    (w_push0),
    .i_push1    (w_push1),
    .i_pop      (w_wr_en),
    .o_mem      (w_mem),
    .o_head     (w_head),
    .o_cnt      (w_cnt),
    .o_cnt_next (w_cnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= state_of(int'(w_cnt_next), DEPTH);
  end

  assign w_wr_en    = (w_cnt != '0);
  assign w_head_ent = w_mem[w_head];

  // Scan oldest to youngest so the last hit leaves the youngest data behind.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    // NOTE: every output of this block gets a default first, so no path
    // through the loop can leave a latch behind.
    w_idx   = '0;
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
`ifdef WR_BYPASS_EN
    w_fwd_a = '0;
    w_fwd_b = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = w_head + PTR_W'(i);
      if (CNT_W'(i) < w_cnt) begin
        if (bus.srcA != RNONE && w_mem[w_idx].addr == bus.srcA) begin
          w_haz_a = 1'b1;
`ifdef WR_BYPASS_EN
          w_fwd_a = w_mem[w_idx].data;
`endif
        end
        if (bus.srcB != RNONE && w_mem[w_idx].addr == bus.srcB) begin
          w_haz_b = 1'b1;
`ifdef WR_BYPASS_EN
          w_fwd_b = w_mem[w_idx].data;
`endif
        end
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.wr_en     = w_wr_en;
  assign bus.wr_addr   = w_wr_en ? w_head_ent.addr : RNONE;
  assign bus.wr_data   = w_wr_en ? w_head_ent.data : '0;
  assign bus.hazA      = w_haz_a;
  assign bus.hazB      = w_haz_b;
  assign bus.pend_cnt  = w_cnt;

`ifdef WR_BYPASS_EN
  assign bus.fwdA_valid = w_haz_a;
  assign bus.fwdA_data  = w_fwd_a;
  assign bus.fwdB_valid = w_haz_b;
  assign bus.fwdB_data  = w_fwd_b;
`endif

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Self-checking bench for regfile_wr_sched: directed scenarios plus random traffic,
// every cycle compared against a queue-based model of the pending writes.
module tb_regfile_wr_sched;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  regfile_wr_sched_if #(.DEPTH(DEPTH)) bus ();

  regfile_wr_sched #(.DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  a;
    logic [63:0] d;
  } wr_t;

  wr_t q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_enq    = 0;
  int  n_wr     = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic model_haz(input logic [3:0] src);
    if (src == 4'hF) return 1'b0;
    foreach (q[i]) if (q[i].a == src) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] model_fwd(input logic [3:0] src);
    logic [63:0] d = '0;
    if (src != 4'hF) foreach (q[i]) if (q[i].a == src) d = q[i].d;
    return d;
  endfunction

  function automatic logic model_ready();
    return (DEPTH - q.size()) >= 2;
  endfunction

  task automatic drive(input logic v, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    bus.req_valid = v;
    bus.dstE      = de;
    bus.valE      = ve;
    bus.dstM      = dm;
    bus.valM      = vm;
  endtask

  // One clock: compare at the falling edge, advance the model, return 1 ns after the rise.
  task automatic tick();
    logic acc;
    @(negedge clk);
    check("wr_en", bus.wr_en, q.size() != 0);
    if (q.size() != 0) begin
      check("wr_addr", bus.wr_addr, q[0].a);
      check("wr_data", bus.wr_data, q[0].d);
    end
    if (bus.wr_en) n_wr++;
    check("pend_cnt", bus.pend_cnt, q.size());
    check("req_ready", bus.req_ready, model_ready());
    check("hazA", bus.hazA, model_haz(bus.srcA));
    check("hazB", bus.hazB, model_haz(bus.srcB));
`ifdef WR_BYPASS_EN
    check("fwdA_valid", bus.fwdA_valid, model_haz(bus.srcA));
    check("fwdA_data", bus.fwdA_data, model_fwd(bus.srcA));
    check("fwdB_valid", bus.fwdB_valid, model_haz(bus.srcB));
    check("fwdB_data", bus.fwdB_data, model_fwd(bus.srcB));
`endif
    acc = bus.req_valid && model_ready();
    if (q.size() != 0) void'(q.pop_front());
    if (acc) begin
      if (bus.dstE != 4'hF) begin q.push_back('{a: bus.dstE, d: bus.valE}); n_enq++; end
      if (bus.dstM != 4'hF) begin q.push_back('{a: bus.dstM, d: bus.valM}); n_enq++; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) tick();
    check({tag, "_empty"}, q.size(), 0);
    tick();
    check({tag, "_count"}, n_wr, n_enq);
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.srcA = 4'hF;
    bus.srcB = 4'hF;
    drive(1'b0, 4'hF, '0, 4'hF, '0);
    #2;
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_wr_addr", bus.wr_addr, 4'hF);
    check("rst_wr_data", bus.wr_data, 64'h0);
    check("rst_pend_cnt", bus.pend_cnt, 0);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_hazA", bus.hazA, 1'b0);
    check("rst_hazB", bus.hazB, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Single E result, M unused.
    drive(1'b1, 4'd3, 64'h11, 4'hF, 64'h0);
    tick();
    bus.req_valid = 1'b0;
    check("s1_wr_en", bus.wr_en, 1'b1);
    check("s1_wr_addr", bus.wr_addr, 4'd3);
    check("s1_wr_data", bus.wr_data, 64'h11);
    tick();
    check("s1_pend_cnt", bus.pend_cnt, 0);
    check("s1_idle", bus.wr_en, 1'b0);

    // popq-like: E then M on consecutive cycles.
    drive(1'b1, 4'd4, 64'h100, 4'd7, 64'hAB);
    tick();
    bus.req_valid = 1'b0;
    check("s2_first_addr", bus.wr_addr, 4'd4);
    check("s2_first_data", bus.wr_data, 64'h100);
    tick();
    check("s2_second_addr", bus.wr_addr, 4'd7);
    check("s2_second_data", bus.wr_data, 64'hAB);
    tick();

    // Same destination: M written last.
    drive(1'b1, 4'd4, 64'h8, 4'd4, 64'h9);
    tick();
    bus.req_valid = 1'b0;
    check("s3_first_data", bus.wr_data, 64'h8);
    tick();
    check("s3_last_addr", bus.wr_addr, 4'd4);
    check("s3_last_data", bus.wr_data, 64'h9);
    tick();

    // No destinations: accepted, nothing queued.
    drive(1'b1, 4'hF, 64'h1, 4'hF, 64'h2);
    tick();
    bus.req_valid = 1'b0;
    check("s4_pend_cnt", bus.pend_cnt, 0);
    check("s4_wr_en", bus.wr_en, 1'b0);

    // Back-to-back two-result requests fill the buffer.
    n_wr  = 0;
    n_enq = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'd1, 64'h1000 + 64'(k), 4'd2, 64'h2000 + 64'(k));
      tick();
      if (k == 1) begin
        check("s5_pend_full", bus.pend_cnt, 3);
        check("s5_ready_low", bus.req_ready, 1'b0);
      end
    end
    drain("s5");

    // Hazard on A only, youngest R5 value forwarded.
    bus.srcA = 4'd5;
    bus.srcB = 4'hF;
    drive(1'b1, 4'd5, 64'h55, 4'd5, 64'h66);
    tick();
    bus.req_valid = 1'b0;
    check("s6_hazA", bus.hazA, 1'b1);
    check("s6_hazB", bus.hazB, 1'b0);
`ifdef WR_BYPASS_EN
    check("s6_fwdA", bus.fwdA_data, 64'h66);
`endif
    tick();
    check("s6_hazA_head", bus.hazA, 1'b1);
    tick();
    check("s6_hazA_clear", bus.hazA, 1'b0);
    bus.srcA = 4'hF;

    // Reset asserted with three entries pending.
    drive(1'b1, 4'd1, 64'hA1, 4'd2, 64'hA2);
    tick();
    drive(1'b1, 4'd3, 64'hA3, 4'd6, 64'hA6);
    tick();
    bus.req_valid = 1'b0;
    check("s7_pending", bus.pend_cnt, 3);
    bus.srcA = 4'd3;
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("s7_wr_en", bus.wr_en, 1'b0);
    check("s7_pend_cnt", bus.pend_cnt, 0);
    check("s7_wr_addr", bus.wr_addr, 4'hF);
    check("s7_hazA", bus.hazA, 1'b0);
    check("s7_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();

    // Random traffic.
    n_wr  = 0;
    n_enq = 0;
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7)),
            {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7)),
            {$urandom, $urandom});
      bus.srcA = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      bus.srcB = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      tick();
    end
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_sched.md
REGFILE_WR_SCHED -- requirements
Module: regfile_wr_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-write entries (power of two, >=2).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_valid  in  1  writeback stage offers one instruction's results.
REQ-005 SHALL have ports: req_ready  out  1  scheduler can accept both results this cycle.
REQ-006 SHALL have ports: dstE  in  4, valE  in  64, dstM  in  4, valM  in  64  (ID 15 = none).
REQ-007 SHALL have ports: wr_en  out  1, wr_addr  out  4, wr_data  out  64  (single register-file write port).
REQ-008 SHALL have ports: srcA  in  4, srcB  in  4  (decode read IDs); hazA  out  1, hazB  out  1  (pending write to that ID).
REQ-009 SHALL have ports: pend_cnt  out  $clog2(DEPTH)+1  (valid entries).

Function
REQ-010 SHALL accept a request on a rising clk edge when req_valid && req_ready.
REQ-011 SHALL assert req_ready iff free entries >= 2, independent of req_valid.
REQ-012 SHALL enqueue dstE/valE then dstM/valM in that order on acceptance, skipping any ID == 15.
REQ-013 SHALL enqueue both entries when dstE == dstM != 15, so M is written last and wins.
REQ-014 SHALL drive wr_en=1 with the head entry's addr/data whenever pend_cnt > 0, retiring one entry per cycle.
REQ-015 SHALL make the first write visible on wr_* the cycle after acceptance (latency 1), never combinationally from request inputs.
REQ-016 SHALL allow acceptance and retirement in the same cycle: pend_cnt_next = pend_cnt + enq_count - retire.
REQ-017 SHALL wrap head/tail pointers modulo DEPTH.
REQ-018 SHALL assert hazX iff srcX != 15 and any valid entry (including the head being written this cycle) has addr == srcX.
REQ-019 SHALL use states EMPTY (cnt=0), ACTIVE (0<cnt<DEPTH-1), NEAR_FULL (cnt>=DEPTH-1, req_ready=0), with transitions purely from pend_cnt_next.
REQ-020 SHALL treat req_valid with both IDs == 15 as accepted with no entries enqueued.

Reset
REQ-021 SHALL on rst_n low: clear all entries, pointers, pend_cnt=0, wr_en=0, wr_addr=15, wr_data=0, hazA=hazB=0, req_ready=1.
REQ-022 SHALL discard pending writes on reset asserted mid-operation; no write issues until after rst_n deasserts.

Configuration
REQ-023 SHALL, with WR_BYPASS_EN defined, add outputs fwdA_valid, fwdA_data[63:0], fwdB_valid, fwdB_data[63:0], giving the youngest pending entry's data matching srcX, valid gated like hazX.
REQ-024 SHALL, without WR_BYPASS_EN, omit these ports and forwarding logic; hazA/hazB are unchanged.

Structure
REQ-025 SHALL put RNONE (4'hF), register-ID width, data width (64) and the entry struct {addr, data} in shared package y86_pkg.
REQ-026 SHALL implement storage/pointers as sub-module wr_fifo; hazard/forward match logic stays in regfile_wr_sched.

Verification
REQ-027 SHALL check: reset, then req dstE=3 valE=0x11, dstM=15 -> next cycle wr_en=1, wr_addr=3, wr_data=0x11, then pend_cnt=0.
REQ-028 SHALL check: popq-like req dstE=4 valE=0x100, dstM=7 valM=0xAB -> writes R4=0x100 then R7=0xAB on consecutive cycles.
REQ-029 SHALL check: dstE=dstM=4, valE=0x8, valM=0x9 -> two writes, last is R4=0x9.
REQ-030 SHALL check: back-to-back two-result requests with DEPTH=4 -> req_ready drops at pend_cnt>=3, no entry lost, write order preserved.
REQ-031 SHALL check: pending write to R5, srcA=5, srcB=15 -> hazA=1, hazB=0 until R5 retires; with WR_BYPASS_EN, fwdA_data equals youngest R5 value.
REQ-032 SHALL check: rst_n pulsed low with 3 entries pending -> wr_en=0 immediately, pend_cnt=0, no later stale writes.
